lag_timer_multi: RTL and testbench

Multi-channel input-lag timer; the parametrised successor of the single-sensor lag measurement path in the top level. A single-cycle `start` (the frame-start trigger, already brought into the `clock` domain) restarts a shared BCD timebase ticking every `CLOCK_DIVIDER` clocks. Each sensor channel captures the timebase on its first active edge. Per-channel min/max statistics are kept, and channels that see no edge before the timebase saturates report a timeout.

---
 rtl/lag_timer_multi.sv | 180 ++++++++++++++++++
 tb/tb_lag_timer_multi.sv | 302 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/lag_timer_multi.sv
// lag_timer_multi: multi-channel input-lag timer with a shared BCD timebase.
// A start pulse restarts the timebase; each channel latches it on its first sensor edge.
//
// Ports:
//   clock, reset_n      sole clock, synchronous active-low reset
//   start               pulse, (re)starts a measurement
//   clear_stats         pulse, resets min/max of all channels
//   sensor              raw asynchronous sensor pins
//   sensor_level        synchronised, polarity-corrected sensor level
//   bcd_current         live timebase value
//   busy                measurement running
//   result              last captured count per channel (packed)
//   result_min/max      per-channel statistics (packed)
//   result_valid        per-channel capture flag, cleared by start
//   result_strobe       per-channel one-cycle capture pulse
//   timeout             per-channel: saturated before any edge
module lag_timer_multi #(
  parameter int CHANNELS          = 2,
  parameter int DIGITS            = 5,
  parameter int CLOCK_DIVIDER     = 270,
  parameter int SENSOR_ACTIVE_LOW = 1
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic                         start,
  input  logic                         clear_stats,
  input  logic [CHANNELS-1:0]          sensor,
  output logic [CHANNELS-1:0]          sensor_level,
  output logic [4*DIGITS-1:0]          bcd_current,
  output logic                         busy,
  output logic [CHANNELS*4*DIGITS-1:0] result,
  output logic [CHANNELS*4*DIGITS-1:0] result_min,
  output logic [CHANNELS*4*DIGITS-1:0] result_max,
  output logic [CHANNELS-1:0]          result_valid,
  output logic [CHANNELS-1:0]          result_strobe,
  output logic [CHANNELS-1:0]          timeout
);

  localparam int W  = 4 * DIGITS;
  localparam int PW = $clog2(CLOCK_DIVIDER);

  localparam logic [PW-1:0] PMAX = PW'(CLOCK_DIVIDER - 1);
  localparam logic [W-1:0]  ALL9 = {DIGITS{4'h9}};

  localparam logic [CHANNELS-1:0] POL =
    {CHANNELS{SENSOR_ACTIVE_LOW != 0}};

  localparam logic [0:0] S_IDLE = 1'b0;
  localparam logic [0:0] S_RUN  = 1'b1;

  logic [0:0]          state_q;
  logic [PW-1:0]       presc_q;
  logic [W-1:0]        bcd_q;
  logic [W-1:0]        bcd_inc;
  logic                carry;
  logic [CHANNELS-1:0] sync1_q;
  logic [CHANNELS-1:0] sync2_q;
  logic [CHANNELS-1:0] prev_q;
  logic [CHANNELS-1:0] waiting_q;
  logic [CHANNELS-1:0] valid_q;
  logic [CHANNELS-1:0] strobe_q;
  logic [CHANNELS-1:0] timeout_q;
  logic [CHANNELS-1:0] rise;
  logic [CHANNELS-1:0] cap;
  logic [CHANNELS-1:0] wait_left;
  logic                run;
  logic                tick;
  logic                sat;

  // Polarity is folded in before the first flop so that cleared
  // synchroniser flops read as "not asserted" for either polarity.
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      sync1_q <= '0;
      sync2_q <= '0;
      prev_q  <= '0;
    end else begin
      sync1_q <= sensor ^ POL;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  assign rise = sync2_q & ~prev_q;
  assign run  = (state_q == S_RUN);
  assign tick = run && (presc_q == PMAX);
  assign sat  = tick && (bcd_q == ALL9);

  // start has priority over any capture in the same cycle.
  assign cap       = (run && !start) ? (rise & waiting_q) : '0;
  assign wait_left = waiting_q & ~cap;

  always_comb begin
    bcd_inc = bcd_q;
    carry   = 1'b1;
    for (int d = 0; d < DIGITS; d++) begin
      if (carry) begin
        if (bcd_q[4*d +: 4] == 4'h9) begin
          bcd_inc[4*d +: 4] = 4'h0;
        end else begin
          bcd_inc[4*d +: 4] = bcd_q[4*d +: 4] + 4'h1;
          carry = 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q   <= S_IDLE;
      presc_q   <= '0;
      bcd_q     <= '0;
      waiting_q <= '0;
      valid_q   <= '0;
      strobe_q  <= '0;
      timeout_q <= '0;
    end else begin
      strobe_q <= cap;
      if (start) begin
        state_q   <= S_RUN;
        presc_q   <= '0;
        bcd_q     <= '0;
        waiting_q <= '1;
        valid_q   <= '0;
        timeout_q <= '0;
      end else if (run) begin
        presc_q <= tick ? '0 : presc_q + PW'(1);
        if (tick && !sat) begin
          bcd_q <= bcd_inc;
        end
        valid_q   <= valid_q | cap;
        waiting_q <= wait_left;
        if (sat) begin
          timeout_q <= timeout_q | wait_left;
          waiting_q <= '0;
          state_q   <= S_IDLE;
        end else if (wait_left == '0) begin
          state_q <= S_IDLE;
        end
      end
    end
  end

  for (genvar g = 0; g < CHANNELS; g++) begin : g_ch
    logic [W-1:0] res_q;
    logic [W-1:0] min_q;
    logic [W-1:0] max_q;

    // A coincident clear makes the sample the new min and max.
    always_ff @(posedge clock) begin
      if (!reset_n) begin
        res_q <= '0;
        min_q <= ALL9;
        max_q <= '0;
      end else begin
        if (clear_stats) begin
          min_q <= ALL9;
          max_q <= '0;
        end
        if (cap[g]) begin
          res_q <= bcd_q;
          if (clear_stats || bcd_q < min_q) min_q <= bcd_q;
          if (clear_stats || bcd_q > max_q) max_q <= bcd_q;
        end
      end
    end

    assign result[g*W +: W]     = res_q;
    assign result_min[g*W +: W] = min_q;
    assign result_max[g*W +: W] = max_q;
  end

  assign sensor_level  = sync2_q;
  assign bcd_current   = bcd_q;
  assign busy          = run;
  assign result_valid  = valid_q;
  assign result_strobe = strobe_q;
  assign timeout       = timeout_q;

endmodule

// File: tb/tb_lag_timer_multi.sv
// tb_lag_timer_multi: directed bench for lag_timer_multi.
// Main instance uses 3 digits / divider 4; a 2-digit instance covers timeout.
module tb_lag_timer_multi;

  localparam int CH  = 2;
  localparam int DG  = 3;
  localparam int DIV = 4;
  localparam int W   = 4 * DG;
  localparam int W2  = 8;

  logic clock = 1'b0;
  always #5 clock = ~clock;

  logic              reset_n;
  logic              start;
  logic              clear_stats;
  logic [CH-1:0]     sensor;
  logic [CH-1:0]     sensor_level;
  logic [W-1:0]      bcd_current;
  logic              busy;
  logic [CH*W-1:0]   result;
  logic [CH*W-1:0]   result_min;
  logic [CH*W-1:0]   result_max;
  logic [CH-1:0]     result_valid;
  logic [CH-1:0]     result_strobe;
  logic [CH-1:0]     timeout;

  logic              start2;
  logic              clear2;
  logic [CH-1:0]     sensor2;
  logic [CH-1:0]     level2;
  logic [W2-1:0]     bcd2;
  logic              busy2;
  logic [CH*W2-1:0]  res2;
  logic [CH*W2-1:0]  min2;
  logic [CH*W2-1:0]  max2;
  logic [CH-1:0]     valid2;
  logic [CH-1:0]     strobe2;
  logic [CH-1:0]     timeout2;

  lag_timer_multi #(
    .CHANNELS(CH), .DIGITS(DG),
    .CLOCK_DIVIDER(DIV), .SENSOR_ACTIVE_LOW(1)
  ) dut (
    .clock(clock), .reset_n(reset_n),
    .start(start), .clear_stats(clear_stats),
    .sensor(sensor), .sensor_level(sensor_level),
    .bcd_current(bcd_current), .busy(busy),
    .result(result), .result_min(result_min),
    .result_max(result_max),
    .result_valid(result_valid),
    .result_strobe(result_strobe),
    .timeout(timeout)
  );

  lag_timer_multi #(
    .CHANNELS(CH), .DIGITS(2),
    .CLOCK_DIVIDER(DIV), .SENSOR_ACTIVE_LOW(1)
  ) dut2 (
    .clock(clock), .reset_n(reset_n),
    .start(start2), .clear_stats(clear2),
    .sensor(sensor2), .sensor_level(level2),
    .bcd_current(bcd2), .busy(busy2),
    .result(res2), .result_min(min2),
    .result_max(max2),
    .result_valid(valid2),
    .result_strobe(strobe2),
    .timeout(timeout2)
  );

  typedef struct {
    logic [11:0] cap;
    logic [11:0] exp_min;
    logic [11:0] exp_max;
  } stat_vec_t;

  stat_vec_t vecs[3];

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string nm,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_total++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h",
                  nm, got, exp);
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_bcd", 32'(bcd_current), 0);
    chk("start_busy", 32'(busy), 1);
    chk("start_valid", 32'(result_valid), 0);
  endtask

  task automatic wait_bcd(input logic [11:0] t);
    int n;
    n = 0;
    while (bcd_current !== t && n < 20000) begin
      step();
      n++;
    end
    chk("wait_bcd", 32'(bcd_current), 32'(t));
  endtask

  // Pin goes active just after bcd changes to t; the capture edge
  // is 3 clocks later, still inside the same timebase step.
  task automatic capture(input logic [11:0] t,
                         input logic clr,
                         input logic [11:0] emin,
                         input logic [11:0] emax,
                         input string nm);
    wait_bcd(t);
    sensor[0] = 1'b0;
    step();
    step();
    chk({nm, "_level"}, 32'(sensor_level[0]), 1);
    chk({nm, "_early_strobe"}, 32'(result_strobe), 0);
    clear_stats = clr;
    step();
    clear_stats = 1'b0;
    chk({nm, "_result"}, 32'(result[11:0]), 32'(t));
    chk({nm, "_strobe"}, 32'(result_strobe), 1);
    chk({nm, "_valid0"}, 32'(result_valid[0]), 1);
    chk({nm, "_min"}, 32'(result_min[11:0]), 32'(emin));
    chk({nm, "_max"}, 32'(result_max[11:0]), 32'(emax));
    step();
    chk({nm, "_strobe_off"}, 32'(result_strobe), 0);
    sensor[0] = 1'b1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic seen;

    vecs[0] = '{12'h050, 12'h050, 12'h050};
    vecs[1] = '{12'h030, 12'h030, 12'h050};
    vecs[2] = '{12'h070, 12'h030, 12'h070};

    reset_n     = 1'b0;
    start       = 1'b0;
    clear_stats = 1'b0;
    start2      = 1'b0;
    clear2      = 1'b0;
    sensor      = 2'b00;
    sensor2     = 2'b11;

    for (int i = 0; i < 3; i++) begin
      sensor = ~sensor ^ 2'(i);
      @(posedge clock);
    end
    #1;
    chk("rst_busy", 32'(busy), 0);
    chk("rst_valid", 32'(result_valid), 0);
    chk("rst_strobe", 32'(result_strobe), 0);
    chk("rst_timeout", 32'(timeout), 0);
    chk("rst_bcd", 32'(bcd_current), 0);
    chk("rst_result", 32'(result), 0);
    chk("rst_max", 32'(result_max), 0);
    chk("rst_min", 32'(result_min), 32'h999999);
    chk("rst_level", 32'(sensor_level), 0);
    chk("rst_min2", 32'(min2), 32'h9999);
    chk("rst_busy2", 32'(busy2), 0);

    sensor  = 2'b11;
    reset_n = 1'b1;
    repeat (4) step();
    chk("idle_level", 32'(sensor_level), 0);
    chk("idle_bcd", 32'(bcd_current), 0);

    // capture at 0x123 and first-tick latency
    pulse_start();
    n = 0;
    while (bcd_current == 0 && n < 100) begin
      step();
      n++;
    end
    chk("first_tick_clocks", 32'(n), DIV);
    chk("first_tick_bcd", 32'(bcd_current), 1);
    capture(12'h123, 1'b0, 12'h123, 12'h123, "cap123");
    chk("cap123_valid1", 32'(result_valid[1]), 0);
    chk("cap123_busy", 32'(busy), 1);

    // restart and ignored second edge
    pulse_start();
    chk("restart_keeps", 32'(result[11:0]), 32'h123);
    capture(12'h010, 1'b0, 12'h010, 12'h123, "cap010");
    repeat (3) step();
    sensor[0] = 1'b0;
    seen = 1'b0;
    repeat (5) begin
      step();
      if (result_strobe[0]) seen = 1'b1;
    end
    chk("second_edge_strobe", 32'(seen), 0);
    chk("second_edge_result", 32'(result[11:0]), 32'h010);
    sensor[0] = 1'b1;
    wait_bcd(12'h040);
    chk("pre_restart_valid", 32'(result_valid[0]), 1);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("restart_bcd", 32'(bcd_current), 0);
    chk("restart_valid", 32'(result_valid), 0);
    chk("restart_result", 32'(result[11:0]), 32'h010);
    chk("restart_busy", 32'(busy), 1);

    // statistics table
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("preclr_min", 32'(result_min[11:0]), 32'h999);
    chk("preclr_max", 32'(result_max[11:0]), 0);
    for (int i = 0; i < 3; i++) begin
      pulse_start();
      capture(vecs[i].cap, 1'b0,
              vecs[i].exp_min, vecs[i].exp_max, "stat");
    end
    chk("stat_min1", 32'(result_min[23:12]), 32'h999);
    chk("stat_max1", 32'(result_max[23:12]), 0);
    clear_stats = 1'b1;
    step();
    clear_stats = 1'b0;
    chk("clr_min", 32'(result_min[11:0]), 32'h999);
    chk("clr_max", 32'(result_max[11:0]), 0);
    pulse_start();
    capture(12'h020, 1'b0, 12'h020, 12'h020, "cap020");
    pulse_start();
    capture(12'h044, 1'b1, 12'h044, 12'h044, "clrcap");

    // start coinciding with a registered edge
    pulse_start();
    wait_bcd(12'h005);
    sensor[0] = 1'b0;
    step();
    step();
    start = 1'b1;
    step();
    start = 1'b0;
    chk("conflict_valid", 32'(result_valid), 0);
    chk("conflict_strobe", 32'(result_strobe), 0);
    chk("conflict_bcd", 32'(bcd_current), 0);
    chk("conflict_busy", 32'(busy), 1);
    step();
    chk("conflict_valid_after", 32'(result_valid), 0);
    chk("conflict_result", 32'(result[11:0]), 32'h044);
    sensor[0] = 1'b1;
    repeat (3) step();

    // both channels in one cycle end the run
    pulse_start();
    wait_bcd(12'h008);
    sensor = 2'b00;
    repeat (3) step();
    chk("dual_strobe", 32'(result_strobe), 32'h3);
    chk("dual_result", 32'(result), 32'h008008);
    chk("dual_busy", 32'(busy), 0);
    repeat (6) step();
    chk("dual_frozen", 32'(bcd_current), 32'h008);
    sensor = 2'b11;

    // timeout on the 2-digit instance
    start2 = 1'b1;
    step();
    start2 = 1'b0;
    n = 0;
    while (bcd2 !== 8'h99 && n < 2000) begin
      step();
      n++;
    end
    chk("to_reach99", 32'(bcd2), 32'h99);
    repeat (3) step();
    chk("to_before", 32'(timeout2), 0);
    chk("to_busy_before", 32'(busy2), 1);
    step();
    chk("to_timeout", 32'(timeout2), 32'h3);
    chk("to_busy", 32'(busy2), 0);
    chk("to_valid", 32'(valid2), 0);
    chk("to_bcd", 32'(bcd2), 32'h99);
    step();
    chk("to_hold", 32'(bcd2), 32'h99);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
